mdi_round_sequencer: RTL
========================

// Module: mdi_round_sequencer
// PURPOSE
//  Preparer/initiator side of the MDI collapse-register protocol. Drives a bank of NUM_CELLS
//  single-use Alice/Bob register pairs (one mdi_qkd_top per cell) one cell at a time.
//  For each cell it takes a symbol (value, basis_a, basis_b) from an RNG and issues init,
//  then a single read strobe. It collects granted (basis-matched) values into a sifted key,
//  checks each round for tamper, and drives the fuse on anomaly. External decode routes
//  init/read to cell_idx and muxes that cell's outputs back.
// PARAMETERS
//  NUM_CELLS  64  cells in bank; each cell is consumed exactly once (kill_latch is never re-armed)
//  KEY_BYTES  4   sifted bytes per emitted key word
//  IDX_W      $clog2(NUM_CELLS)  cell index width (derived)
// PORTS
//  clk            in   1           clock
//  reset_n        in   1           async active-low reset
//  start          in   1           begin run; honoured only in IDLE
//  rng_valid      in   1           RNG word available
//  rng_ready      out  1           RNG word consumed this cycle
//  rng_data       in   12          [11:4] value, [3:2] basis_a, [1:0] basis_b
//  cell_idx       out  IDX_W       cell currently addressed
//  init_o         out  1           init strobe to cell_idx
//  read_o         out  1           read strobe to cell_idx
//  value_o        out  8           value driven to both value_a and value_b
//  basis_a_o      out  2           basis to Alice register
//  basis_b_o      out  2           basis to Bob register
//  out_a, out_b   in   8           muxed value_out of addressed cell (combinational)
//  pad_en_a/b     in   1           muxed pad_enable of addressed cell
//  fuse_blow_o    out  1           1-cycle pulse to fuse_blow_a and fuse_blow_b of cell_idx
//  key_valid      out  1           key_data valid
//  key_ready      in   1           consumer accepts key
//  key_data       out  8*KEY_BYTES sifted key; first sifted byte in MSBs
//  busy           out  1           not IDLE/DONE/TAMPER
//  exhausted      out  1           all cells consumed (sticky)
//  tamper         out  1           anomaly detected (sticky)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cell_idx 0, byte count 0. No output is driven
//   from rng_data before rng_ready.
//  FSM: IDLE -start-> FETCH -rng_valid-> LOAD -> READ -> {FETCH | EMIT | DONE | TAMPER}.
//  FETCH: rng_ready = rng_valid. On a transfer, latch value/bases into the output regs.
//   Stalls indefinitely while rng_valid = 0.
//  LOAD: init_o = 1 for exactly 1 cycle. The cell's basis_out is registered, so the grant
//   is valid on the next cycle.
//  READ: read_o = 1 for exactly 1 cycle. Sample out_a, out_b, pad_en_a, pad_en_b in this
//   same cycle. match = (basis_a_o == basis_b_o).
//  Tamper (any, evaluated in READ):
//   - pad_en_a != pad_en_b
//   - pad_en_a != match
//   - pad_en_a && (out_a != value_o || out_b != value_o)
//  On tamper: next state TAMPER; fuse_blow_o pulses 1 cycle on entry; tamper = 1.
//  Otherwise, if pad_en_a: shift key_data left 8 and insert out_a; count++.
//  After READ:
//   - count == KEY_BYTES -> EMIT.
//   - Else if cell_idx == NUM_CELLS-1 -> DONE with exhausted = 1.
//   - Else cell_idx++ -> FETCH.
//   - A cell is never revisited; cell_idx never wraps.
//  EMIT: key_valid = 1 and key_data stable until key_ready. On handshake: count = 0,
//   key_valid = 0. Next state is FETCH with cell_idx+1, or DONE if the last cell was used.
//   key_ready while not key_valid is ignored.
//  DONE / TAMPER: terminal until reset_n. start is ignored. A partial key (count > 0) is
//   discarded and never emitted.
//  start asserted while busy: ignored. Simultaneous rng_valid and start in IDLE: the RNG
//   word is not consumed until FETCH.
//  reset_n mid-round (any state): immediate return to reset values. Cells are not
//   re-armed by this block.
//  Round latency without RNG stall: 3 cycles per cell (FETCH, LOAD, READ).
// STRUCTURE
//  mdi_pkg:
//   - seq_state_e {IDLE, FETCH, LOAD, READ, EMIT, DONE, TAMPER}
//   - rng_word_t struct {value[7:0], basis_a[1:0], basis_b[1:0]}
//   - BASIS_W = 2, VALUE_W = 8
//  Sub-module mdi_key_packer: shift register plus byte counter. Ports: clk, reset_n,
//   push, byte_in, clear, full, key_data. Remaining FSM and tamper check live in this module.
// TESTING
//  Bank model: NUM_CELLS instances of mdi_qkd_top with decode/mux; NUM_CELLS=8, KEY_BYTES=2.
//  1 Matched bases: rng value=0x3C, bases 01/01, then value=0x5A, bases 10/10 ->
//    pad_en high both rounds; key_valid with key_data=0x3C5A after cell 1 READ.
//  2 Mismatched bases: value=0x11, bases 00/11 -> pad_en low, no key shift, cell_idx
//    advances 0->1, tamper = 0.
//  3 Exhaustion: 8 rounds all mismatched -> DONE, exhausted = 1, key_valid never set;
//    start afterwards ignored.
//  4 Fuse tamper: pre-blow fuse of cell 2, then matched round on cell 2 -> pad_en low with
//    match -> TAMPER, fuse_blow_o pulses exactly 1 cycle, tamper stays 1.
//  5 Backpressure/stall: hold key_ready = 0 for 10 cycles in EMIT -> key_data stable, no
//    rng_ready. Drop rng_valid in FETCH -> no init_o until valid.
//  6 Reset mid-READ: deassert reset_n during read_o -> all outputs 0 asynchronously,
//    state IDLE.

Source files
------------

// File: rtl/mdi_pkg.sv
// Shared types for the MDI round sequencer: FSM states, RNG word layout
// and datapath widths.
package mdi_pkg;

  localparam int BASIS_W = 2;
  localparam int VALUE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    READ,
    EMIT,
    DONE,
    TAMPER
  } seq_state_e;

  typedef struct packed {
    logic [VALUE_W-1:0] value;
    logic [BASIS_W-1:0] basis_a;
    logic [BASIS_W-1:0] basis_b;
  } rng_word_t;

endpackage

// File: rtl/mdi_key_packer.sv
// Sifted-key accumulator: byte shift register (first byte ends in MSBs)
// with a fill counter.
module mdi_key_packer
  import mdi_pkg::*;
#(
  parameter int KEY_BYTES = 4,
  localparam int KEY_W = VALUE_W * KEY_BYTES,
  localparam int CNT_W = $clog2(KEY_BYTES + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic [VALUE_W-1:0] byte_in,
  input  logic               clear,
  output logic               full,
  output logic [KEY_W-1:0]   key_data
);

  logic [CNT_W-1:0] cnt_q;
  logic [KEY_W-1:0] data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (push) begin
      cnt_q  <= cnt_q + CNT_W'(1);
      data_q <= (data_q << VALUE_W) | KEY_W'(byte_in);
    end
  end

  // Full as seen after this cycle, so the FSM can branch on the final push.
  assign full = (cnt_q == CNT_W'(KEY_BYTES)) ||
                (push && (cnt_q == CNT_W'(KEY_BYTES - 1)));

  assign key_data = data_q;

endmodule

// File: rtl/mdi_round_sequencer.sv
// Initiator for the MDI collapse-register bank: one init/read round per
// cell, sifts matched values into key words and fuses the cell on anomaly.
module mdi_round_sequencer
  import mdi_pkg::*;
#(
  parameter int NUM_CELLS = 64,
  parameter int KEY_BYTES = 4,
  localparam int IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1,
  localparam int KEY_W = VALUE_W * KEY_BYTES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               rng_valid,
  output logic               rng_ready,
  input  logic [11:0]        rng_data,
  output logic [IDX_W-1:0]   cell_idx,
  output logic               init_o,
  output logic               read_o,
  output logic [VALUE_W-1:0] value_o,
  output logic [BASIS_W-1:0] basis_a_o,
  output logic [BASIS_W-1:0] basis_b_o,
  input  logic [VALUE_W-1:0] out_a,
  input  logic [VALUE_W-1:0] out_b,
  input  logic               pad_en_a,
  input  logic               pad_en_b,
  output logic               fuse_blow_o,
  output logic               key_valid,
  input  logic               key_ready,
  output logic [KEY_W-1:0]   key_data,
  output logic               busy,
  output logic               exhausted,
  output logic               tamper
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CELLS - 1);

  seq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VALUE_W-1:0] value_q;
  logic [BASIS_W-1:0] ba_q, bb_q;
  logic               exh_q, exh_d;
  logic               tmp_q, tmp_d;
  logic               fuse_q, fuse_d;
  rng_word_t          rng_w;
  logic               xfer, match, anomaly, last;
  logic               push, clear, full;

  assign rng_w = rng_data;
  assign xfer  = (state_q == FETCH) && rng_valid;
  assign last  = (idx_q == LAST);
  assign match = (ba_q == bb_q);

  // A granted pad must agree on both sides and return exactly what we loaded.
  assign anomaly = (pad_en_a != pad_en_b) ||
                   (pad_en_a != match) ||
                   (pad_en_a && ((out_a != value_q) || (out_b != value_q)));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    exh_d     = exh_q;
    tmp_d     = tmp_q;
    fuse_d    = 1'b0;
    rng_ready = 1'b0;
    init_o    = 1'b0;
    read_o    = 1'b0;
    key_valid = 1'b0;
    push      = 1'b0;
    clear     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        rng_ready = rng_valid;
        if (rng_valid) state_d = LOAD;
      end
      LOAD: begin
        init_o  = 1'b1;
        state_d = READ;
      end
      READ: begin
        read_o = 1'b1;
        if (anomaly) begin
          state_d = TAMPER;
          tmp_d   = 1'b1;
          fuse_d  = 1'b1;
        end else begin
          push = pad_en_a;
          if (full) begin
            state_d = EMIT;
          end else if (last) begin
            state_d = DONE;
            exh_d   = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = FETCH;
          end
        end
      end
      EMIT: begin
        key_valid = 1'b1;
        if (key_ready) begin
          clear = 1'b1;
          if (last) begin
            state_d = DONE;
            exh_d   = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = FETCH;
          end
        end
      end
      DONE, TAMPER: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      value_q <= '0;
      ba_q    <= '0;
      bb_q    <= '0;
      exh_q   <= 1'b0;
      tmp_q   <= 1'b0;
      fuse_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exh_q   <= exh_d;
      tmp_q   <= tmp_d;
      fuse_q  <= fuse_d;
      if (xfer) begin
        value_q <= rng_w.value;
        ba_q    <= rng_w.basis_a;
        bb_q    <= rng_w.basis_b;
      end
    end
  end

  mdi_key_packer #(
    .KEY_BYTES(KEY_BYTES)
  ) u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .byte_in (out_a),
    .clear   (clear),
    .full    (full),
    .key_data(key_data)
  );

  assign cell_idx    = idx_q;
  assign value_o     = value_q;
  assign basis_a_o   = ba_q;
  assign basis_b_o   = bb_q;
  assign fuse_blow_o = fuse_q;
  assign exhausted   = exh_q;
  assign tamper      = tmp_q;
  assign busy        = !(state_q inside {IDLE, DONE, TAMPER});

endmodule
